branch_resolve_stage: RTL and testbench
=======================================

Name: branch_resolve_stage

Overview:
- Consumes the EQ/LT/LTu flags produced by the 32-bit comparator tree, together with branch funct3, prediction and PC/target.
- Resolves taken/not-taken, mispredict and redirect PC.
- Buffers results behind a registered valid/ready pipeline stage with a 2-entry skid buffer.
- Sits between the execute-stage comparator and the fetch redirect / commit logic; also keeps saturating branch and mispredict counters.

Parameters:
- XLEN, 32, width of pc, target and redirect PC.
- CW, 16, width of the statistics counters.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream branch valid.
- in_ready  output  1  stage can accept a branch this cycle.
- funct3  input  3  branch funct3.
- eq  input  1  comparator EQ.
- lt  input  1  comparator LT (signed).
- ltu  input  1  comparator LTu (unsigned).
- pred_taken  input  1  front-end prediction.
- pc  input  XLEN  branch PC.
- target  input  XLEN  computed branch target.
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  resolved result valid.
- out_ready  input  1  downstream accepts.
- out_taken  output  1  resolved direction.
- out_mispredict  output  1  out_taken != pred_taken, or illegal with pred_taken=1.
- out_illegal  output  1  funct3 is 010 or 011.
- out_redirect_pc  output  XLEN  correct next PC.
- branch_cnt  output  CW  completed branches, saturating.
- mispred_cnt  output  CW  completed mispredicts, saturating.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs are 0 except in_ready=1. Buffer state is EMPTY and counters are 0. Deassertion is used synchronously by the surrounding reset synchroniser.
- Decode (combinational on inputs):
  - 000 taken=eq; 001 taken=~eq.
  - 100 taken=lt; 101 taken=~lt.
  - 110 taken=ltu; 111 taken=~ltu.
  - 010 and 011: illegal=1, taken=0.
- Redirect PC: redirect = taken ? target : pc+4, computed modulo 2^XLEN (pc = all-ones+1 wraps).
- Mispredict: mispredict = taken ^ pred_taken. An illegal funct3 therefore mispredicts iff pred_taken=1.
- Result payload is {taken, mispredict, illegal, redirect}, captured on input handshake (in_valid & in_ready).
- Latency is 1 cycle: a branch accepted at cycle N appears on out_* at cycle N+1 when the buffer was EMPTY.
- Buffer states and out_valid:
  - EMPTY: out_valid=0.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- in_ready is registered and equals (state != FULL).
- Transitions (acc = input handshake, dq = out_valid & out_ready):
  - EMPTY: acc -> ONE.
  - ONE: acc & ~dq -> FULL (new into skid); acc & dq -> ONE (new into main); ~acc & dq -> EMPTY; else hold.
  - FULL: dq -> ONE (skid moves to main); else hold.
- Ordering: results always leave in acceptance order. out_* are stable while out_valid=1 and out_ready=0.
- Flush (synchronous, highest priority): next state is EMPTY and in_ready=1 the next cycle. An input presented in the flush cycle is dropped. A dq in the flush cycle still counts as delivered.
- Counters:
  - On dq, branch_cnt increments.
  - On dq with out_mispredict=1, mispred_cnt also increments.
  - Both saturate at 2^CW-1 (no wrap) and are unaffected by flush.

Test Plan:
- Reset with reset_n=0 mid-traffic in FULL state -> immediately out_valid=0, in_ready=1, counters 0.
- BLT, eq=0 lt=1, pred_taken=0, pc=0x100, target=0x80, out_ready=1 -> next cycle out_taken=1, out_mispredict=1, out_redirect_pc=0x80; mispred_cnt=1 after dq.
- BGEU with ltu=1, pred_taken=0, pc=0xFFFFFFFC -> out_taken=0, mispredict=0, redirect=0x00000000 (wrap).
- Back-pressure: three branches issued with out_ready=0 -> first two accepted, in_ready=0 after second, third held. Then release out_ready=1 -> outputs in order A,B,C, one per cycle; branch_cnt=3.
- funct3=011, pred_taken=1 -> out_illegal=1, out_taken=0, out_mispredict=1, redirect=pc+4.
- Flush while FULL with in_valid=1 and out_valid&out_ready=1 -> next cycle out_valid=0, in_ready=1; branch_cnt +1 only; input dropped.
- CW=4: 20 dequeues -> branch_cnt saturates at 15.

Source files
------------

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: decodes comparator flags into direction, mispredict and redirect PC,
// then presents results through a registered valid/ready stage with a 2-entry skid buffer.
module branch_resolve_stage #(
    parameter int XLEN = 32,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            eq,
    input  logic            lt,
    input  logic            ltu,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_redirect_pc,
    output logic [CW-1:0]   branch_cnt,
    output logic [CW-1:0]   mispred_cnt,
    output logic [1:0]      state_dbg
);

    localparam int PW = XLEN + 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic [PW-1:0]   new_payload;
    logic            taken;
    logic            illegal;
    logic            acc;
    logic            dq;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // a producer holding valid keeps its payload stable until that edge.
    assign acc = in_valid & in_ready;
    assign dq  = out_valid & out_ready;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = eq;
            3'b001:  taken = ~eq;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: illegal = 1'b1;
        endcase
    end

    assign new_payload = {taken, taken ^ pred_taken, illegal,
                          taken ? target : pc + XLEN'(4)};

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (acc) state_next = ONE;
                ONE:     if (acc && !dq) state_next = FULL;
                         else if (!acc && dq) state_next = EMPTY;
                FULL:    if (dq) state_next = ONE;
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
            if (!flush) begin
                case (state)
                    EMPTY:   if (acc) main_q <= new_payload;
                    ONE:     if (acc && dq) main_q <= new_payload;
                             else if (acc) skid_q <= new_payload;
                    FULL:    if (dq) main_q <= skid_q;
                    default: ;
                endcase
            end
            // Delivery counts even in a flush cycle; both counters stick at all-ones.
            if (dq && branch_cnt != {CW{1'b1}})
                branch_cnt <= branch_cnt + CW'(1);
            if (dq && out_mispredict && mispred_cnt != {CW{1'b1}})
                mispred_cnt <= mispred_cnt + CW'(1);
        end
    end

    assign {out_taken, out_mispredict, out_illegal, out_redirect_pc} = main_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed + scoreboard bench for branch_resolve_stage; a CW=4 copy shares all inputs
// to exercise counter saturation.
module tb_branch_resolve_stage;

    localparam int XLEN = 32;
    localparam int PW   = XLEN + 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic [2:0]      funct3;
    logic            eq, lt, ltu, pred_taken;
    logic [XLEN-1:0] pc, target;
    logic            flush;
    logic            out_ready;

    logic            in_ready, out_valid, out_taken, out_mispredict, out_illegal;
    logic [XLEN-1:0] out_redirect_pc;
    logic [15:0]     branch_cnt, mispred_cnt;
    logic [1:0]      state_dbg;

    logic            in_ready4, out_valid4, out_taken4, out_mispredict4, out_illegal4;
    logic [XLEN-1:0] out_redirect_pc4;
    logic [3:0]      branch_cnt4, mispred_cnt4;
    logic [1:0]      state_dbg4;

    int              n_cmp = 0;
    int              n_err = 0;
    int              mis_exp = 0;
    logic [PW-1:0]   exp_q[$];

    always #5 clk = ~clk;

    branch_resolve_stage #(.XLEN(XLEN), .CW(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .eq(eq), .lt(lt), .ltu(ltu), .pred_taken(pred_taken),
        .pc(pc), .target(target), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .out_redirect_pc(out_redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .state_dbg(state_dbg)
    );

    branch_resolve_stage #(.XLEN(XLEN), .CW(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .funct3(funct3), .eq(eq), .lt(lt), .ltu(ltu), .pred_taken(pred_taken),
        .pc(pc), .target(target), .flush(flush), .out_valid(out_valid4),
        .out_ready(out_ready), .out_taken(out_taken4), .out_mispredict(out_mispredict4),
        .out_illegal(out_illegal4), .out_redirect_pc(out_redirect_pc4),
        .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4), .state_dbg(state_dbg4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {taken, mispredict, illegal, redirect}
    function automatic logic [PW-1:0] model(input logic [2:0] f, input logic e, input logic l,
                                            input logic lu, input logic p,
                                            input logic [XLEN-1:0] pcv, input logic [XLEN-1:0] tg);
        logic t, il;
        logic [XLEN-1:0] nxt;
        t  = 1'b0;
        il = 1'b0;
        if (f == 3'b010 || f == 3'b011) il = 1'b1;
        else if (f[2:1] == 2'b00) t = e ^ f[0];
        else if (f[2:1] == 2'b10) t = l ^ f[0];
        else t = lu ^ f[0];
        nxt = pcv + 32'd4;
        return {t, t ^ p, il, t ? tg : nxt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic e, input logic l,
                         input logic lu, input logic p, input logic [XLEN-1:0] pcv,
                         input logic [XLEN-1:0] tg);
        in_valid = v; funct3 = f; eq = e; lt = l; ltu = lu; pred_taken = p;
        pc = pcv; target = tg;
    endtask

    // Scoreboard: push on accepted input, drop everything on flush/reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(model(funct3, eq, lt, ltu, pred_taken, pc, target));
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", out_valid, 0);
            end else begin
                logic [PW-1:0] e;
                e = exp_q.pop_front();
                check("sb_payload", {out_taken, out_mispredict, out_illegal, out_redirect_pc}, e);
                check("sb_payload4", {out_taken4, out_mispredict4, out_illegal4, out_redirect_pc4}, e);
            end
        end
    end

    initial begin
        logic [PW-1:0] r;
        reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(0, 3'b000, 0, 0, 0, 0, '0, '0);
        tick(); tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_payload", {out_taken, out_mispredict, out_illegal, out_redirect_pc}, 0);
        check("rst_cnt", {branch_cnt, mispred_cnt}, 0);
        reset_n = 1'b1;

        // BLT taken, predicted not-taken
        out_ready = 1'b1;
        drive(1, 3'b100, 0, 1, 0, 0, 32'h100, 32'h80);
        tick();
        check("blt_valid", out_valid, 1);
        check("blt_taken", out_taken, 1);
        check("blt_mispredict", out_mispredict, 1);
        check("blt_redirect", out_redirect_pc, 32'h80);
        in_valid = 1'b0;
        tick();
        check("blt_cnts", {branch_cnt, mispred_cnt}, {16'd1, 16'd1});
        check("blt_drained", out_valid, 0);

        // BGEU not taken with pc+4 wrap
        drive(1, 3'b111, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h1234);
        tick();
        check("bgeu_taken", out_taken, 0);
        check("bgeu_mispredict", out_mispredict, 0);
        check("bgeu_redirect_wrap", out_redirect_pc, 32'h0);
        in_valid = 1'b0;
        tick();
        check("bgeu_cnts", {branch_cnt, mispred_cnt}, {16'd2, 16'd1});

        // Back-pressure: A, B fill the buffer, C waits
        out_ready = 1'b0;
        drive(1, 3'b000, 1, 0, 0, 1, 32'h200, 32'h300);
        tick();
        check("bp_ready_after_a", in_ready, 1);
        drive(1, 3'b001, 1, 0, 0, 1, 32'h400, 32'h500);
        tick();
        check("bp_ready_after_b", in_ready, 0);
        check("bp_state_full", state_dbg, 2);
        check("bp_state_full4", state_dbg4, 2);
        drive(1, 3'b101, 0, 0, 0, 0, 32'h600, 32'h700);
        tick();
        check("bp_c_held", in_ready, 0);
        check("bp_stable_a", out_redirect_pc, 32'h300);
        out_ready = 1'b1;
        tick();
        check("bp_out_b", out_redirect_pc, 32'h404);
        tick();
        check("bp_out_c", out_redirect_pc, 32'h700);
        in_valid = 1'b0;
        tick();
        check("bp_cnts", {branch_cnt, mispred_cnt}, {16'd5, 16'd3});
        check("bp_empty", out_valid, 0);

        // Illegal funct3 predicted taken
        drive(1, 3'b011, 1, 1, 1, 1, 32'h1000, 32'h2000);
        tick();
        check("ill_flags", {out_illegal, out_taken, out_mispredict}, 3'b101);
        check("ill_redirect", out_redirect_pc, 32'h1004);
        in_valid = 1'b0;
        tick();
        check("ill_cnts", {branch_cnt, mispred_cnt}, {16'd6, 16'd4});

        // Flush while FULL, with a delivery and a new input in the same cycle
        out_ready = 1'b0;
        drive(1, 3'b110, 0, 0, 1, 1, 32'h3000, 32'h3800);
        tick();
        drive(1, 3'b000, 0, 0, 0, 1, 32'h4000, 32'h4800);
        tick();
        drive(1, 3'b001, 0, 0, 0, 0, 32'h5000, 32'h5800);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_cnts", {branch_cnt, mispred_cnt}, {16'd7, 16'd4});
        tick();
        check("flush_dropped", out_valid, 0);
        check("flush_cnt_hold", branch_cnt, 7);

        // Streaming random traffic, one per cycle, saturating the CW=4 copy
        mis_exp = 4;
        for (int i = 0; i < 20; i++) begin
            drive(1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            r = model(funct3, eq, lt, ltu, pred_taken, pc, target);
            if (r[XLEN+1]) mis_exp++;
            tick();
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_branch_cnt", branch_cnt, 27);
        check("stream_mispred_cnt", mispred_cnt, mis_exp);
        check("sat_branch_cnt4", branch_cnt4, 15);
        check("sat_mispred_cnt4", mispred_cnt4, (mis_exp > 15) ? 15 : mis_exp);

        // Asynchronous reset in the middle of FULL traffic
        out_ready = 1'b0;
        drive(1, 3'b000, 1, 0, 0, 0, 32'h6000, 32'h6800);
        tick(); tick();
        check("mid_full", state_dbg, 2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {out_valid, out_valid4}, 0);
        check("mid_rst_in_ready", {in_ready, in_ready4}, 2'b11);
        check("mid_rst_cnts", {branch_cnt, mispred_cnt, branch_cnt4, mispred_cnt4}, 0);
        check("mid_rst_state", state_dbg, 0);
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
